ram_arbiter: RTL and testbench

- Shares the single Ram32b data memory between two requesters: the MultiCycleCpu memory port (port 0, "cpu") and a debug/program-loader port (port 1, "dbg").
- Sits between both requesters and the Ram32b address/readEnable/writeEnable/writeData/readData pins.
- Serialises accesses with a req/ack handshake, arbitrates simultaneous requests, and returns read data per port.

---
 rtl/ram_arbiter_pkg.sv | 13 +
 rtl/ram_arbiter_if.sv | 49 ++++
 rtl/rr_pick2.sv | 25 ++
 rtl/ram_arbiter.sv | 113 +++++++++++
 tb/tb_ram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port Ram32b arbiter.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DBG = 1'b1;

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester and memory-side signals of the arbiter, bundled for port connection.
interface ram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;
    logic              grant_id;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
        output mem_addr, mem_read, mem_write, mem_wdata,
        output busy, grant_id
    );

    // Requesters plus memory, seen from outside the arbiter
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, dbg_ack, dbg_rdata,
        input  mem_addr, mem_read, mem_write, mem_wdata,
        input  busy, grant_id
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way winner select: a lone requester wins; ties go to the port other than
// last when rr_en is set, otherwise to the cpu.
module rr_pick2
    import ram_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    input  logic rr_en,
    output logic winner,
    output logic valid
);

    assign valid = req0 | req1;

    always_comb begin
        winner = PORT_CPU;
        if (req0 && req1) begin
            winner = rr_en ? ~last : PORT_CPU;
        end else if (req1) begin
            winner = PORT_DBG;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises cpu and dbg accesses onto the single Ram32b port with a req/ack
// handshake; every access takes MEM_LATENCY cycles followed by a one-cycle ack.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | memory quiet, sampling both requests for the next grant
//   S_ACCESS | driving latched op; read held MEM_LATENCY cycles, write 1
//   S_ACK    | one-cycle ack pulse to the granted port
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int ROUND_ROBIN = 1
) (
    input  logic          clk,
    input  logic          rst,
    ram_arbiter_if.slave  bus
);

    localparam int              CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last;
    logic              op_we;

    logic              pick_winner;
    logic              pick_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_pick2 u_pick (
        .req0   (bus.cpu_req),
        .req1   (bus.dbg_req),
        .last   (last),
        .rr_en  (ROUND_ROBIN != 0),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    assign sel_we    = (pick_winner == PORT_DBG) ? bus.dbg_we    : bus.cpu_we;
    assign sel_addr  = (pick_winner == PORT_DBG) ? bus.dbg_addr  : bus.cpu_addr;
    assign sel_wdata = (pick_winner == PORT_DBG) ? bus.dbg_wdata : bus.cpu_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            cnt           <= '0;
            last          <= PORT_DBG;
            op_we         <= 1'b0;
            bus.cpu_ack   <= 1'b0;
            bus.dbg_ack   <= 1'b0;
            bus.cpu_rdata <= '0;
            bus.dbg_rdata <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            bus.busy      <= 1'b0;
            bus.grant_id  <= PORT_CPU;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        state         <= S_ACCESS;
                        cnt           <= CNT_LOAD;
                        op_we         <= sel_we;
                        bus.grant_id  <= pick_winner;
                        bus.mem_addr  <= sel_addr;
                        bus.mem_wdata <= sel_wdata;
                        bus.mem_read  <= ~sel_we;
                        bus.mem_write <= sel_we;
                        bus.busy      <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    // Writes strobe once; the remaining cycles keep timing uniform.
                    bus.mem_write <= 1'b0;
                    if (cnt == '0) begin
                        state         <= S_ACK;
                        last          <= bus.grant_id;
                        bus.mem_read  <= 1'b0;
                        bus.mem_addr  <= '0;
                        bus.mem_wdata <= '0;
                        if (bus.grant_id == PORT_DBG) begin
                            bus.dbg_ack <= 1'b1;
                            if (!op_we) bus.dbg_rdata <= bus.mem_rdata;
                        end else begin
                            bus.cpu_ack <= 1'b1;
                            if (!op_we) bus.cpu_rdata <= bus.mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_ACK: begin
                    state       <= S_IDLE;
                    bus.cpu_ack <= 1'b0;
                    bus.dbg_ack <= 1'b0;
                    bus.busy    <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Three arbiter instances (RR latency 1, fixed-priority latency 1, RR latency 3)
// each with a small RAM model; a negedge monitor checks acks against a queue.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        cpu_req [3], cpu_we [3], dbg_req [3], dbg_we [3];
    logic [31:0] cpu_addr [3], cpu_wdata [3], dbg_addr [3], dbg_wdata [3];
    logic        cpu_ack [3], dbg_ack [3], mem_read [3], mem_write [3], busy [3], grant_id [3];
    logic [31:0] cpu_rdata [3], dbg_rdata [3], mem_addr [3], mem_wdata [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          unit;
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [31:0] exp_rd [3][2];
    int          pulse [3];

    function automatic int ml_of(input int u);
        return (u == 2) ? 3 : 1;
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : gen_unit
            localparam int ML = (g == 2) ? 3 : 1;
            localparam int RR = (g == 1) ? 0 : 1;

            ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
            logic [31:0] mem [256];
            int          rd_cnt = 0;

            assign bus.cpu_req   = cpu_req[g];
            assign bus.cpu_we    = cpu_we[g];
            assign bus.cpu_addr  = cpu_addr[g];
            assign bus.cpu_wdata = cpu_wdata[g];
            assign bus.dbg_req   = dbg_req[g];
            assign bus.dbg_we    = dbg_we[g];
            assign bus.dbg_addr  = dbg_addr[g];
            assign bus.dbg_wdata = dbg_wdata[g];

            assign cpu_ack[g]   = bus.cpu_ack;
            assign dbg_ack[g]   = bus.dbg_ack;
            assign cpu_rdata[g] = bus.cpu_rdata;
            assign dbg_rdata[g] = bus.dbg_rdata;
            assign mem_read[g]  = bus.mem_read;
            assign mem_write[g] = bus.mem_write;
            assign mem_addr[g]  = bus.mem_addr;
            assign mem_wdata[g] = bus.mem_wdata;
            assign busy[g]      = bus.busy;
            assign grant_id[g]  = bus.grant_id;

            // Read data is only valid once mem_read has been held ML cycles.
            assign bus.mem_rdata = (bus.mem_read && rd_cnt >= ML - 1) ?
                                   mem[bus.mem_addr[9:2]] : 32'hBAD0_BAD0;

            always @(posedge clk) begin
                if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
                rd_cnt <= bus.mem_read ? rd_cnt + 1 : 0;
            end

            ram_arbiter #(
                .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(ML), .ROUND_ROBIN(RR)
            ) dut (
                .clk (clk),
                .rst (rst),
                .bus (bus)
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every ack and every active memory cycle with the queue.
    always @(negedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (mem_read[u] || mem_write[u]) begin
                pulse[u]++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_activity unit=%0d actual=active required=idle", u);
                end else begin
                    chk("mem_addr", mem_addr[u], exp_q[0].addr);
                    chk("mem_is_write", 32'(mem_write[u]), 32'(exp_q[0].we));
                    if (mem_write[u]) chk("mem_wdata", mem_wdata[u], exp_q[0].wdata);
                end
            end
            if (cpu_ack[u] || dbg_ack[u]) begin
                chk("ack_exclusive", 32'(cpu_ack[u] && dbg_ack[u]), 32'd0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack unit=%0d actual=ack required=none", u);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("ack_unit", 32'(u), 32'(mon_e.unit));
                    chk("ack_port", 32'(dbg_ack[u]), 32'(mon_e.port));
                    chk("grant_id", 32'(grant_id[u]), 32'(mon_e.port));
                    chk("busy_in_ack", 32'(busy[u]), 32'd1);
                    if (mon_e.cyc >= 0) chk("ack_cycle", 32'(cyc), 32'(mon_e.cyc));
                    chk("mem_pulse_len", 32'(pulse[u]), mon_e.we ? 32'd1 : 32'(ml_of(u)));
                    if (!mon_e.we) exp_rd[u][mon_e.port] = mon_e.rdata;
                    chk("cpu_rdata", cpu_rdata[u], exp_rd[u][0]);
                    chk("dbg_rdata", dbg_rdata[u], exp_rd[u][1]);
                end
                pulse[u] = 0;
            end
        end
    end

    task automatic drive(input int u, input logic port, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (port == PORT_DBG) begin
            dbg_we[u] = we; dbg_addr[u] = addr; dbg_wdata[u] = wdata; dbg_req[u] = 1'b1;
        end else begin
            cpu_we[u] = we; cpu_addr[u] = addr; cpu_wdata[u] = wdata; cpu_req[u] = 1'b1;
        end
    endtask

    task automatic push(input int u, input logic port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int c);
        exp_t e;
        e.unit = u; e.port = port; e.we = we; e.addr = addr;
        e.wdata = wdata; e.rdata = rdata; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input int u, input string name);
        bit got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cpu_ack[u] || dbg_ack[u]) got = 1;
        end
        cpu_req[u] = 1'b0;
        dbg_req[u] = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s_timeout unit=%0d actual=no ack required=ack", name, u);
        end
    endtask

    task automatic access(input int u, input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata);
        @(posedge clk); #1;
        push(u, port, we, addr, we ? wdata : 32'h0, rdata, cyc + 1 + ml_of(u));
        drive(u, port, we, addr, wdata);
        wait_ack(u, "access");
    endtask

    task automatic tie(input int u, input logic winner, input logic [31:0] rd_c, input logic [31:0] rd_d);
        @(posedge clk); #1;
        push(u, winner, 1'b0, (winner == PORT_DBG) ? 32'h14 : 32'h10, 32'h0,
             (winner == PORT_DBG) ? rd_d : rd_c, cyc + 1 + ml_of(u));
        drive(u, PORT_CPU, 1'b0, 32'h10, 32'h0);
        drive(u, PORT_DBG, 1'b0, 32'h14, 32'h0);
        wait_ack(u, "tie");
    endtask

    task automatic clear_model();
        exp_q.delete();
        for (int u = 0; u < 3; u++) begin
            exp_rd[u][0] = 32'h0;
            exp_rd[u][1] = 32'h0;
            pulse[u] = 0;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        #1;
        chk("rst_cpu_rdata", cpu_rdata[0], 32'h0);
        chk("rst_dbg_rdata", dbg_rdata[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : main
        int c;
        int n;
        bit done;
        for (int u = 0; u < 3; u++) begin
            cpu_req[u] = 0; cpu_we[u] = 0; cpu_addr[u] = 0; cpu_wdata[u] = 0;
            dbg_req[u] = 0; dbg_we[u] = 0; dbg_addr[u] = 0; dbg_wdata[u] = 0;
        end
        clear_model();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 3; u++) begin
            chk("reset_mem_read", 32'(mem_read[u]), 32'd0);
            chk("reset_mem_write", 32'(mem_write[u]), 32'd0);
            chk("reset_busy", 32'(busy[u]), 32'd0);
            chk("reset_grant_id", 32'(grant_id[u]), 32'd0);
            chk("reset_acks", 32'(cpu_ack[u] | dbg_ack[u]), 32'd0);
            chk("reset_mem_addr", mem_addr[u], 32'h0);
            chk("reset_rdata", cpu_rdata[u] | dbg_rdata[u], 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Unit 0: latency 1, round robin
        access(0, PORT_DBG, 1'b1, 32'h14, 32'hA5A5_5A5A, 32'h0);
        access(0, PORT_CPU, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0);
        access(0, PORT_CPU, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        access(0, PORT_DBG, 1'b0, 32'h14, 32'h0, 32'hA5A5_5A5A);
        pulse_reset();
        tie(0, PORT_CPU, 32'hDEAD_BEEF, 32'hA5A5_5A5A);
        tie(0, PORT_DBG, 32'hDEAD_BEEF, 32'hA5A5_5A5A);
        tie(0, PORT_CPU, 32'hDEAD_BEEF, 32'hA5A5_5A5A);
        tie(0, PORT_DBG, 32'hDEAD_BEEF, 32'hA5A5_5A5A);

        // Unit 1: fixed priority, both requests held; cpu served until it lets go
        access(1, PORT_CPU, 1'b1, 32'h40, 32'h1357_9BDF, 32'h0);
        access(1, PORT_DBG, 1'b1, 32'h44, 32'h2468_ACE0, 32'h0);
        @(posedge clk); #1;
        c = cyc;
        push(1, PORT_CPU, 1'b0, 32'h40, 32'h0, 32'h1357_9BDF, c + 2);
        push(1, PORT_CPU, 1'b0, 32'h40, 32'h0, 32'h1357_9BDF, c + 5);
        push(1, PORT_CPU, 1'b0, 32'h40, 32'h0, 32'h1357_9BDF, c + 8);
        push(1, PORT_DBG, 1'b0, 32'h44, 32'h0, 32'h2468_ACE0, c + 11);
        drive(1, PORT_CPU, 1'b0, 32'h40, 32'h0);
        drive(1, PORT_DBG, 1'b0, 32'h44, 32'h0);
        n = 0;
        done = 0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (cpu_ack[1]) begin
                n++;
                if (n == 3) cpu_req[1] = 1'b0;
            end
            if (dbg_ack[1]) begin
                dbg_req[1] = 1'b0;
                done = 1;
            end
        end
        cpu_req[1] = 1'b0;
        chk("fixed_prio_dbg_acked", 32'(done), 32'd1);
        chk("fixed_prio_cpu_acks", 32'(n), 32'd3);

        // Unit 2: latency 3
        access(2, PORT_DBG, 1'b1, 32'h30, 32'h1111_1111, 32'h0);
        access(2, PORT_DBG, 1'b1, 32'h20, 32'h1234_5678, 32'h0);
        access(2, PORT_CPU, 1'b1, 32'h24, 32'h55AA_55AA, 32'h0);
        access(2, PORT_CPU, 1'b0, 32'h24, 32'h0, 32'h55AA_55AA);
        access(2, PORT_DBG, 1'b0, 32'h20, 32'h0, 32'h1234_5678);

        // Reset in the first ACCESS cycle of a dbg write; the write must be lost
        @(posedge clk); #1;
        push(2, PORT_DBG, 1'b1, 32'h30, 32'hCAFE_F00D, 32'h0, -1);
        drive(2, PORT_DBG, 1'b1, 32'h30, 32'hCAFE_F00D);
        @(posedge clk); #1;
        chk("pre_rst_mem_write", 32'(mem_write[2]), 32'd1);
        #1;
        rst = 1'b1;
        dbg_req[2] = 1'b0;
        clear_model();
        #1;
        chk("rst_mid_mem_write", 32'(mem_write[2]), 32'd0);
        chk("rst_mid_busy", 32'(busy[2]), 32'd0);
        chk("rst_mid_dbg_ack", 32'(dbg_ack[2]), 32'd0);
        chk("rst_mid_mem_addr", mem_addr[2], 32'h0);
        chk("rst_mid_cpu_rdata", cpu_rdata[2], 32'h0);
        chk("rst_mid_dbg_rdata", dbg_rdata[2], 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        access(2, PORT_CPU, 1'b0, 32'h30, 32'h0, 32'h1111_1111);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
